// File: rtl/karatsuba_operand_stager.sv
`timescale 1ns/1ps
// karatsuba_operand_stager: word-serial operand packer and product streamer for the Karatsuba core
// Optional WAIT-state watchdog enabled by defining KARATSUBA_STAGER_WDOG_EN.
module karatsuba_operand_stager #(
    parameter int WordWidth     = 32,
    parameter int InputALength  = 131,
    parameter int InputBLength  = 127,
    parameter int ProductLength = 264,
    parameter int WdogCycles    = 1024
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic [WordWidth-1:0]     in_data_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [WordWidth-1:0]     out_data_o,
    output logic                     out_last_o,
    output logic [InputALength-1:0]  acc_a_o,
    output logic [InputBLength-1:0]  acc_b_o,
    output logic                     acc_start_o,
    input  logic                     acc_done_i,
    input  logic [ProductLength-1:0] acc_product_i,
    output logic                     busy_o,
    output logic                     error_o
);
    localparam int NA   = (InputALength + WordWidth - 1) / WordWidth;
    localparam int NB   = (InputBLength + WordWidth - 1) / WordWidth;
    localparam int NP   = (ProductLength + WordWidth - 1) / WordWidth;
    localparam int ExtA = NA * WordWidth;
    localparam int ExtB = NB * WordWidth;
    localparam int ExtP = NP * WordWidth;
    localparam int CntW = $clog2(NA + NB + NP);
    typedef enum logic [2:0] {LOAD_A, LOAD_B, FIRE, WAIT, UNLOAD} stateT;
    stateT state;
    logic [CntW-1:0] cnt;
    logic [InputALength-1:0] accA, aMask, aIns;
    logic [InputBLength-1:0] accB, bMask, bIns;
    logic [ProductLength-1:0] product;
    logic [WordWidth-1:0] outData, nextWord;
    logic [31:0] inShift, outShift;
    logic inReady, outValid, outLast, accStart, lastA, lastB, lastP;
`ifdef KARATSUBA_STAGER_WDOG_EN
    localparam int WdW = $clog2(WdogCycles + 1);
    logic [WdW-1:0] wdog;
    logic errQ;
    assign error_o = errQ;
`else
    assign error_o = 1'b0;
`endif
    // Word k occupies bits [k*W +: W]; the casts drop bits beyond the operand/product width.
    assign inShift  = 32'(cnt) * 32'(WordWidth);
    assign outShift = 32'(cnt + 1'b1) * 32'(WordWidth);
    assign aMask    = InputALength'(ExtA'({WordWidth{1'b1}}) << inShift);
    assign aIns     = InputALength'(ExtA'(in_data_i) << inShift);
    assign bMask    = InputBLength'(ExtB'({WordWidth{1'b1}}) << inShift);
    assign bIns     = InputBLength'(ExtB'(in_data_i) << inShift);
    assign nextWord = WordWidth'(ExtP'(product) >> outShift);
    assign lastA    = cnt == CntW'(NA - 1);
    assign lastB    = cnt == CntW'(NB - 1);
    assign lastP    = cnt == CntW'(NP - 1);
    assign in_ready_o  = inReady;
    assign out_valid_o = outValid;
    assign out_data_o  = outData;
    assign out_last_o  = outLast;
    assign acc_a_o     = accA;
    assign acc_b_o     = accB;
    assign acc_start_o = accStart;
    assign busy_o      = !(state == LOAD_A && cnt == '0);
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state    <= LOAD_A;
            cnt      <= '0;
            accA     <= '0;
            accB     <= '0;
            product  <= '0;
            outData  <= '0;
            inReady  <= 1'b1;
            outValid <= 1'b0;
            outLast  <= 1'b0;
            accStart <= 1'b0;
`ifdef KARATSUBA_STAGER_WDOG_EN
            wdog     <= '0;
            errQ     <= 1'b0;
`endif
        end else begin
            case (state)
                LOAD_A: if (in_valid_i) begin
                    accA  <= (accA & ~aMask) | aIns;
                    cnt   <= lastA ? '0 : cnt + 1'b1;
                    state <= lastA ? LOAD_B : LOAD_A;
                end
                LOAD_B: if (in_valid_i) begin
                    accB     <= (accB & ~bMask) | bIns;
                    cnt      <= lastB ? '0 : cnt + 1'b1;
                    state    <= lastB ? FIRE : LOAD_B;
                    inReady  <= !lastB;
                    accStart <= lastB;
                end
                FIRE: begin
                    accStart <= 1'b0;
                    state    <= WAIT;
`ifdef KARATSUBA_STAGER_WDOG_EN
                    wdog     <= '0;
`endif
                end
                WAIT: if (acc_done_i) begin
                    product  <= acc_product_i;
                    outData  <= WordWidth'(ExtP'(acc_product_i));
                    outValid <= 1'b1;
                    outLast  <= NP == 1;
                    state    <= UNLOAD;
                end
`ifdef KARATSUBA_STAGER_WDOG_EN
                else if (wdog == WdW'(WdogCycles - 1)) begin
                    errQ     <= 1'b1;
                    product  <= '0;
                    outData  <= '0;
                    outValid <= 1'b1;
                    outLast  <= NP == 1;
                    state    <= UNLOAD;
                end else wdog <= wdog + 1'b1;
`endif
                UNLOAD: if (out_ready_i) begin
                    cnt      <= lastP ? '0 : cnt + 1'b1;
                    outData  <= lastP ? '0 : nextWord;
                    outLast  <= !lastP && (cnt + 1'b1 == CntW'(NP - 1));
                    outValid <= !lastP;
                    inReady  <= lastP;
                    state    <= lastP ? LOAD_A : UNLOAD;
                end
                default: begin
                    state    <= LOAD_A;
                    cnt      <= '0;
                    outData  <= '0;
                    inReady  <= 1'b1;
                    outValid <= 1'b0;
                    outLast  <= 1'b0;
                    accStart <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_karatsuba_operand_stager.sv
`timescale 1ns/1ps
// tb_karatsuba_operand_stager: randomized bench with a behavioural multiplier core and product scoreboard
module tb_karatsuba_operand_stager;
    localparam int W = 32, LA = 131, LB = 127, LP = 264, NA = 5, NB = 4, NP = 9;
`ifdef KARATSUBA_STAGER_WDOG_EN
    localparam int Wd = 16;
`else
    localparam int Wd = 1024;
`endif
    logic clk_i = 0, rst_ni = 0, in_valid_i = 0, out_ready_i = 0, acc_done_i = 0;
    logic [W-1:0] in_data_i = '0;
    logic [LP-1:0] acc_product_i = '0;
    logic in_ready_o, out_valid_o, out_last_o, acc_start_o, busy_o, error_o;
    logic [W-1:0] out_data_o;
    logic [LA-1:0] acc_a_o, coreA;
    logic [LB-1:0] acc_b_o, coreB;
    int checks = 0, errors = 0, coreLat = 20, startPulses = 0, ops = 0;
    bit coreEn = 1, wdogSeen = 0;

    karatsuba_operand_stager #(.WordWidth(W), .InputALength(LA), .InputBLength(LB),
        .ProductLength(LP), .WdogCycles(Wd)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .in_data_i(in_data_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_data_o(out_data_o), .out_last_o(out_last_o), .acc_a_o(acc_a_o), .acc_b_o(acc_b_o),
        .acc_start_o(acc_start_o), .acc_done_i(acc_done_i), .acc_product_i(acc_product_i),
        .busy_o(busy_o), .error_o(error_o));

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [299:0] obs, input logic [299:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Core model: fixed latency, product = A*B of the operands seen at start.
    initial forever begin
        @(negedge clk_i);
        if (acc_start_o) begin
            startPulses++;
            if (coreEn) begin
                coreA = acc_a_o;
                coreB = acc_b_o;
                repeat (coreLat - 1) @(negedge clk_i);
                acc_product_i = LP'(coreA) * LP'(coreB);
                acc_done_i = 1;
                @(negedge clk_i);
                acc_done_i = 0;
                check("done_to_valid", out_valid_o, 1);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    task automatic sendWord(input logic [W-1:0] w, input bit gap);
        int t = 0;
        in_valid_i = 1;
        in_data_i = w;
        while (!in_ready_o && t < 50) begin
            @(negedge clk_i);
            t++;
        end
        check("in_ready_wait", t < 50, 1);
        @(negedge clk_i);
        if (gap) begin
            in_valid_i = 0;
            @(negedge clk_i);
        end
    endtask

    task automatic collect(input logic [287:0] expP, input int bpWord);
        logic [W-1:0] held;
        for (int k = 0; k < NP; k++) begin
            int t = 0;
            out_ready_i = 1;
            while (!out_valid_o && t < 200) begin
                @(negedge clk_i);
                t++;
            end
            check("out_valid_wait", t < 200, 1);
            if (k == bpWord) begin
                out_ready_i = 0;
                held = out_data_o;
                repeat (3) begin
                    @(negedge clk_i);
                    check("bp_hold_data", out_data_o, held);
                    check("bp_hold_valid", out_valid_o, 1);
                end
                out_ready_i = 1;
            end
            check($sformatf("word%0d", k), out_data_o, W'(expP >> (k * W)));
            check($sformatf("last%0d", k), out_last_o, k == NP - 1);
            @(negedge clk_i);
        end
        out_ready_i = 0;
        check("out_valid_after", out_valid_o, 0);
    endtask

    task automatic runOp(input logic [NA*W-1:0] aw, input logic [NB*W-1:0] bw, input bit gaps,
                         input int bpWord, input bit waitJunk, input bit wdogExp);
        logic [LA-1:0] expA = aw[LA-1:0];
        logic [LB-1:0] expB = bw[LB-1:0];
        logic [287:0] expP = wdogExp ? '0 : 288'(LP'(expA) * LP'(expB));
        for (int k = 0; k < NA; k++) sendWord(W'(aw >> (k * W)), gaps);
        for (int k = 0; k < NB; k++) sendWord(W'(bw >> (k * W)), gaps && k < NB - 1);
        in_valid_i = waitJunk;
        in_data_i = $urandom;
        check("start_high", acc_start_o, 1);
        check("fire_ready", in_ready_o, 0);
        check("busy", busy_o, 1);
        check("acc_a", acc_a_o, expA);
        check("acc_b", acc_b_o, expB);
        @(negedge clk_i);
        check("start_low", acc_start_o, 0);
        if (waitJunk) repeat (3) begin
            @(negedge clk_i);
            check("wait_ready", in_ready_o, 0);
        end
        in_valid_i = 0;
        if (wdogExp) begin
            repeat (15) @(negedge clk_i);
            check("wdog_before", error_o, 0);
            @(negedge clk_i);
            check("wdog_error", error_o, 1);
            wdogSeen = 1;
        end
        collect(expP, bpWord);
        ops++;
        check("start_pulses", startPulses, ops);
        check("idle_ready", in_ready_o, 1);
        check("idle_busy", busy_o, 0);
        check("error", error_o, wdogSeen);
    endtask

    initial begin
        repeat (3) @(negedge clk_i);
        check("rst_in_ready", in_ready_o, 1);
        check("rst_out_valid", out_valid_o, 0);
        check("rst_out_data", out_data_o, 0);
        check("rst_out_last", out_last_o, 0);
        check("rst_acc_a", acc_a_o, 0);
        check("rst_acc_b", acc_b_o, 0);
        check("rst_start", acc_start_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_error", error_o, 0);
        rst_ni = 1;
        @(negedge clk_i);
`ifdef KARATSUBA_STAGER_WDOG_EN
        coreLat = 8;
`endif
        runOp(160'd1, 128'd1, 0, -1, 0, 0);
        runOp('1, '1, 0, 4, 0, 0);
        runOp({$urandom, $urandom, $urandom, $urandom, $urandom},
              {$urandom, $urandom, $urandom, $urandom}, 1, -1, 1, 0);
        for (int k = 0; k < 3; k++) sendWord($urandom, 0);
        in_valid_i = 0;
        rst_ni = 0;
        @(negedge clk_i);
        check("midrst_ready", in_ready_o, 1);
        check("midrst_busy", busy_o, 0);
        check("midrst_acc_a", acc_a_o, 0);
        rst_ni = 1;
        @(negedge clk_i);
        runOp({$urandom, $urandom, $urandom, $urandom, 32'h1234_5678},
              {$urandom, $urandom, $urandom, $urandom}, 0, -1, 0, 0);
        for (int i = 0; i < 4; i++)
            runOp({$urandom, $urandom, $urandom, $urandom, $urandom},
                  {$urandom, $urandom, $urandom, $urandom}, 1'($urandom),
                  ($urandom % 2) ? int'($urandom % NP) : -1, 1'($urandom), 0);
`ifdef KARATSUBA_STAGER_WDOG_EN
        coreEn = 0;
        runOp({$urandom, $urandom, $urandom, $urandom, $urandom},
              {$urandom, $urandom, $urandom, $urandom}, 0, -1, 0, 1);
        coreEn = 1;
        runOp(160'd3, 128'd5, 0, -1, 0, 0);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
